// File: rtl/mdu_e.sv
// RV32M execute-stage multiply/divide unit: multiplies in a short fixed latency,
// divides with a 32-step restoring divider, and stalls the pipeline while it works.
module mdu_e #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             startE,
  input  logic [2:0]       funct3E,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic [4:0]       rdE,
  input  logic             flushE,
  output logic             busyE,
  output logic             doneE,
  output logic [WIDTH-1:0] resultE,
  output logic [4:0]       rdDoneE
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q, result_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q, rd_done_q, cnt_q;
  logic             qneg_q, rneg_q;

  logic             sdiv, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res;

  // Operand conditioning for divides, evaluated on the live E-stage operands.
  always_comb begin
    sdiv     = ~funct3E[0];
    a_neg    = sdiv & srcAE[WIDTH-1];
    b_neg    = sdiv & srcBE[WIDTH-1];
    a_mag    = a_neg ? (~srcAE + 1'b1) : srcAE;
    b_mag    = b_neg ? (~srcBE + 1'b1) : srcBE;
    div_zero = (srcBE == '0);
    div_ovf  = sdiv && (srcAE == {1'b1, {(WIDTH-1){1'b0}}}) && (srcBE == '1);
    // Overflow quotient equals the dividend (most negative value).
    if (div_zero) spec_res = funct3E[1] ? srcAE : '1;
    else          spec_res = funct3E[1] ? '0 : srcAE;
  end

  logic                   mul_a_sgn, mul_b_sgn;
  logic [2*WIDTH-1:0]     mul_a, mul_b, prod;
  logic [WIDTH-1:0]       mul_res;

  // A 64-bit truncated product of sign/zero-extended operands holds every RV32M result exactly.
  always_comb begin
    mul_a_sgn = (f3_q == 3'b001) || (f3_q == 3'b010);
    mul_b_sgn = (f3_q == 3'b001);
    mul_a     = {{WIDTH{mul_a_sgn & a_q[WIDTH-1]}}, a_q};
    mul_b     = {{WIDTH{mul_b_sgn & b_q[WIDTH-1]}}, b_q};
    prod      = mul_a * mul_b;
    mul_res   = (f3_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  logic [WIDTH:0]   rem_sh;
  logic             q_bit;
  logic [WIDTH-1:0] rem_n, quo_n, q_fix, r_fix, div_res;

  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    q_bit   = (rem_sh >= {1'b0, b_q});
    rem_n   = q_bit ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
    quo_n   = {quo_q[WIDTH-2:0], q_bit};
    q_fix   = qneg_q ? (~quo_n + 1'b1) : quo_n;
    r_fix   = rneg_q ? (~rem_n + 1'b1) : rem_n;
    div_res = f3_q[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      rd_done_q <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (startE && !flushE) begin
            f3_q <= funct3E;
            rd_q <= rdE;
            if (!funct3E[2]) begin
              a_q     <= srcAE;
              b_q     <= srcBE;
              state_q <= S_MUL;
            end else if (div_zero || div_ovf) begin
              result_q  <= spec_res;
              rd_done_q <= rdE;
              state_q   <= S_DONE;
            end else begin
              quo_q   <= a_mag;
              b_q     <= b_mag;
              rem_q   <= '0;
              cnt_q   <= '0;
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (flushE) begin
            state_q <= S_IDLE;
          end else begin
            result_q  <= mul_res;
            rd_done_q <= rd_q;
            state_q   <= S_DONE;
          end
        end
        S_DIV: begin
          if (flushE) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              result_q  <= div_res;
              rd_done_q <= rd_q;
              state_q   <= S_DONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busyE   = ((state_q == S_IDLE) && startE && !flushE) || (state_q == S_MUL) || (state_q == S_DIV);
  assign doneE   = (state_q == S_DONE);
  assign resultE = result_q;
  assign rdDoneE = rd_done_q;

endmodule

// File: tb/tb_mdu_e.sv
// Scoreboard bench for mdu_e: the driver queues expected results, a negedge
// monitor pops and compares whenever doneE is presented.
module tb_mdu_e;

  logic        clk = 1'b0;
  logic        rst_n, startE, flushE;
  logic [2:0]  funct3E;
  logic [31:0] srcAE, srcBE;
  logic [4:0]  rdE;
  logic        busyE, doneE;
  logic [31:0] resultE;
  logic [4:0]  rdDoneE;

  always #5 clk = ~clk;

  mdu_e #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .startE(startE), .funct3E(funct3E),
    .srcAE(srcAE), .srcBE(srcBE), .rdE(rdE), .flushE(flushE),
    .busyE(busyE), .doneE(doneE), .resultE(resultE), .rdDoneE(rdDoneE)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding op.
  always @(negedge clk) begin
    if (doneE === 1'b1) begin
      check("done_not_consecutive", {31'd0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h rd %0d, expected no completion", resultE, rdDoneE);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", resultE, e.res);
        check("rd_tag", {27'd0, rdDoneE}, {27'd0, e.rd});
        check("done_cycle", cyc, e.cyc);
      end
    end
    done_prev = (doneE === 1'b1);
  end

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int busy_n;
    logic got;
    @(posedge clk); #1;
    startE  = 1'b1;
    flushE  = 1'b0;
    funct3E = f3;
    srcAE   = a;
    srcBE   = b;
    rdE     = rd;
    sb.push_back('{exp, rd, cyc + lat - 1});
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (busyE === 1'b1) busy_n++;
      if (doneE === 1'b1) got = 1'b1;
    end
    if (!got) $display("op %s timed out", name);
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
    check({name, "_busy_cycles"}, busy_n, lat - 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    startE = 1'b0;
    flushE = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; startE = 1'b0; flushE = 1'b0;
    funct3E = 3'd0; srcAE = '0; srcBE = '0; rdE = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busyE}, 32'd0);
    check("reset_done", {31'd0, doneE}, 32'd0);
    check("reset_result", resultE, 32'd0);
    check("reset_rd", {27'd0, rdDoneE}, 32'd0);

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 3);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 3);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 3);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 3);
    run_op("mul_lo", 3'b000, 32'h12345678, 32'h00000010, 5'd5, 32'h23456780, 3);
    idle();
    run_op("div_neg",  3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 34);
    run_op("rem_neg",  3'b110, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 34);
    run_op("divu_b2b", 3'b101, 32'd100,      32'd7, 5'd8, 32'd14,       34);
    run_op("remu",     3'b111, 32'd100,      32'd7, 5'd9, 32'd2,        34);
    idle();
    run_op("divu_by0", 3'b101, 32'h1234,     32'd0,        5'd10, 32'hFFFFFFFF, 2);
    run_op("remu_by0", 3'b111, 32'h1234,     32'd0,        5'd11, 32'h00001234, 2);
    run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 2);
    run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 2);
    run_op("div_by0",  3'b100, 32'hFFFFFFFB, 32'd0,        5'd14, 32'hFFFFFFFF, 2);
    run_op("rem_by0",  3'b110, 32'hFFFFFFFB, 32'd0,        5'd15, 32'hFFFFFFFB, 2);
    run_op("div_negb", 3'b100, 32'd20,       32'hFFFFFFFA, 5'd16, 32'hFFFFFFFD, 34);
    run_op("rem_negb", 3'b110, 32'd20,       32'hFFFFFFFA, 5'd17, 32'h00000002, 34);
    idle();

    // Flush on the start cycle: no stall, no completion.
    @(posedge clk); #1;
    startE = 1'b1; flushE = 1'b1; funct3E = 3'b000; srcAE = 32'd3; srcBE = 32'd5; rdE = 5'd20;
    @(negedge clk);
    check("flush_start_busy", {31'd0, busyE}, 32'd0);
    idle();
    repeat (5) @(posedge clk);

    // Flush during divide step 5.
    @(posedge clk); #1;
    startE = 1'b1; flushE = 1'b0; funct3E = 3'b101; srcAE = 32'd1000; srcBE = 32'd3; rdE = 5'd21;
    repeat (6) @(posedge clk);
    #1 flushE = 1'b1;
    @(negedge clk);
    check("flush_div_busy_before", {31'd0, busyE}, 32'd1);
    idle();
    @(negedge clk);
    check("flush_div_busy_after", {31'd0, busyE}, 32'd0);
    check("flush_div_done_after", {31'd0, doneE}, 32'd0);
    repeat (40) @(posedge clk);

    // Reset during divide step 10.
    @(posedge clk); #1;
    startE = 1'b1; flushE = 1'b0; funct3E = 3'b100; srcAE = 32'd999; srcBE = 32'd4; rdE = 5'd22;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0; startE = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busyE}, 32'd0);
    check("rst_mid_done", {31'd0, doneE}, 32'd0);
    check("rst_mid_result", resultE, 32'd0);
    check("rst_mid_rd", {27'd0, rdDoneE}, 32'd0);
    repeat (40) @(posedge clk);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_e.md
# mdu_e

Execute-stage RV32M multiply/divide unit. It consumes the operands, `funct3E` and `rdE` held in the decode-to-execute pipeline register. It runs MUL/MULH/MULHSU/MULHU in a fixed short latency and DIV/DIVU/REM/REMU with an iterative restoring divider. While it works, it holds the pipeline through `busyE`, which feeds the hazard unit's stall logic.

## Interface
- `WIDTH`, default 32: datapath width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `startE`  in  1  the instruction in E is an M-extension op (opcode 0110011, funct7 0000001); decoded by control.
- `funct3E`  in  3  RV32M operation select.
- `srcAE`, `srcBE`  in  WIDTH  forwarded rs1/rs2 operands.
- `rdE`  in  5  destination register of the op.
- `flushE`  in  1  squash the op in E.
- `busyE`  out  1  stall request: hold F/D/E and bubble M.
- `doneE`  out  1  `resultE` is valid this cycle.
- `resultE`  out  WIDTH  op result, selected into the ALU-result path when `doneE` is high.
- `rdDoneE`  out  5  destination register tag of the completed op.

## Operation
- funct3 encoding:
  - 000 MUL: low 32 bits of the product.
  - 001 MULH: high 32 bits, signed×signed.
  - 010 MULHSU: high 32 bits, signed×unsigned.
  - 011 MULHU: high 32 bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, MUL, DIV, DONE.
- IDLE, with `startE` high and `flushE` low:
  - Latch the operands, funct3 and rd.
  - funct3[2]=0 goes to MUL.
  - funct3[2]=1 with a special case goes to DONE.
  - funct3[2]=1 otherwise goes to DIV with the counter at 0.
- MUL: form the 64-bit product, sign-extending each operand to 33 bits per op. Register the selected half and go to DONE.
- DIV:
  - On entry, signed ops take operand magnitudes and record the quotient sign (signA^signB) and remainder sign (signA).
  - Each cycle performs one restoring step: shift the remainder/quotient pair left, trial-subtract the divisor, and set the quotient bit when the result is non-negative.
  - The 5-bit counter increments each step. Go to DONE after step 31 (32 steps), applying the sign fixup and funct3 select.
- Special cases, resolved in IDLE with no iteration:
  - Divisor 0: quotient 0xFFFFFFFF (DIV and DIVU); remainder = dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DONE: `doneE`=1. `resultE` and `rdDoneE` are stable. Go to IDLE on the next edge unconditionally. `startE` is ignored in DONE, because the same instruction is still in E.
- `busyE` = (IDLE & `startE` & !`flushE`) | MUL | DIV. It is combinational, so the stall covers the start cycle.
- `flushE` high in any state: next state is IDLE and the op is dropped (no DONE, no `doneE`).
- Reset: state IDLE, counter 0, all internal registers 0, `resultE`=0, `rdDoneE`=0, `doneE`=0, `busyE`=0.
- Reset mid-operation: the unit is in IDLE after the reset edge and no result is produced.
- `resultE` and `rdDoneE` hold their last value outside DONE.

## Timing
- Cycle counts below count the cycles the instruction stays in E. Cycle 1 is the cycle in which `startE` is first seen in IDLE.
- Multiply:
  - Cycle 1 IDLE, cycle 2 MUL, cycle 3 DONE.
  - `busyE` is high in cycles 1-2.
  - The instruction advances to M at the edge ending cycle 3.
- Divide, normal:
  - Cycle 1 IDLE, cycles 2-33 DIV, cycle 34 DONE.
  - `busyE` is high in cycles 1-33.
- Divide, special case:
  - Cycle 1 IDLE, cycle 2 DONE.
  - `busyE` is high in cycle 1 only.
- `startE` may be high again in the cycle right after DONE (back-to-back M ops), and the unit accepts it with no idle gap.
- `doneE` is never high for two consecutive cycles.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `resultE`=0xFFFFFFEB with `doneE` in cycle 3. `busyE` is high exactly 2 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, with `doneE` in cycle 34 and `busyE` high exactly 33 cycles. Back-to-back DIVU 100/7 → 14 starts in the cycle after DONE.
- DIVU 0x1234/0 → 0xFFFFFFFF and REMU 0x1234/0 → 0x1234, with `doneE` in cycle 2. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
- `rst_n` low at DIV step 10 → the next cycle is IDLE with `busyE`=0, `doneE`=0, `resultE`=0, and no `doneE` follows.
- `flushE` asserted with `startE` in IDLE → `busyE`=0 that cycle and no `doneE`. `flushE` during DIV step 5 → IDLE next cycle and no `doneE`.
